servo_pwm_multi: RTL and testbench
==================================

Name: servo_pwm_multi

Overview:
Multi-channel RC-servo pulse generator, the parametrised successor to the single-channel servo tester. Shares one frame counter across NUM_CH channels. Each channel holds a host-written target position and slews its current position toward that target by a bounded step per frame. Each channel drives one glitch-free registered pulse per frame whose width is linear in its current position; the block sits between a register/host interface and the servo output pins.

Parameters:
NUM_CH, 4, number of servo channels (1..16)
POS_W, 8, position width in bits; positions 0..2^POS_W-1
PERIOD, 200000, frame length in clk cycles
MIN_PULSE, 10000, pulse width in cycles at position 0
SCALE, 39, extra pulse cycles per position LSB; MIN_PULSE+(2^POS_W-1)*SCALE < PERIOD, enforced by elaboration check
STEP, 4, maximum position change per frame (ramp rate), >=1
RESET_POS, 128, target and current position after reset and after failsafe
FAILSAFE_FRAMES, 50, frames without a write before failsafe trips (only with the macro)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
enable  input  1  run enable; low freezes frame counter and ramps, forces outputs low
wr_en  input  1  single-cycle write strobe
wr_ch  input  CH_W=max(1,clog2(NUM_CH))  channel index for write
wr_pos  input  POS_W  target position for write
pwm_out  output  NUM_CH  servo pulse per channel, registered
frame_start  output  1  one-cycle pulse on first cycle of each frame, registered
at_target  output  NUM_CH  bit i high when current position == target position of channel i
failsafe  output  1  high while failsafe is active; constant 0 without the macro

Behaviour:
- Reset (async assert, sync release): frame count=0; all targets and currents=RESET_POS; pwm_out=0; frame_start=0; failsafe=0; at_target=all ones.
- Frame counter runs 0..PERIOD-1 and wraps while enable=1. First frame starts on the first enabled cycle after reset release.
- frame_start=1 exactly in the cycle the counter is 0.
- Pulse width W_i = MIN_PULSE + cur_pos_i*SCALE. Compute it at full width CNT_W=clog2(PERIOD); no truncation.
- pwm_out[i] is high for exactly W_i consecutive cycles, starting in the frame_start cycle. Outputs are registered from next-state values, so they are glitch-free.
- cur_pos_i changes only at the frame boundary (counter PERIOD-1 -> 0), so width is constant within a frame.
- Ramp, evaluated at each boundary:
  - if target>cur: cur<=min(cur+STEP,target)
  - if target<cur: cur<=max(cur-STEP,target)
  - no overshoot, no wrap-around at 0 or 2^POS_W-1
- Writes:
  - wr_en with wr_ch<NUM_CH sets target[wr_ch]<=wr_pos on the next edge.
  - wr_ch>=NUM_CH is ignored.
  - Writes are accepted regardless of enable.
- Write coinciding with a frame boundary: the ramp uses the pre-write target; the new target takes effect at the following boundary.
- Latency: a write takes effect on the pulse at the earliest in the frame after the next boundary, i.e. 1 to 2 frames.
- enable=0:
  - counter holds its value; ramps frozen; pwm_out=0 and frame_start=0 from the next cycle.
  - On re-enable, counter restarts from 0 with a full frame.
- Reset mid-frame truncates the pulse immediately (async).

Optional Feature:
Macro SERVO_PWM_FAILSAFE_EN.
With the macro:
- A frame-count watchdog increments at each boundary and clears on any valid write.
- When it reaches FAILSAFE_FRAMES, all targets are loaded with RESET_POS and failsafe=1. Channels ramp there at STEP per frame.
- failsafe clears on the next valid write. That write also sets its channel's target as normal.
- A write in the trip cycle wins, and failsafe does not assert.
Without the macro: no watchdog logic; failsafe tied 0; FAILSAFE_FRAMES unused.

Decomposition:
- Package servo_pwm_pkg: clog2 helper, CNT_W/CH_W derivation, the width-check constant.
- Sub-module servo_pwm_channel, instantiated NUM_CH times via generate. It holds target/cur registers, the ramp step, width compute, and the pwm compare/register.
- The top holds the frame counter, write decode, enable gating and watchdog.

Test Plan:
- Reset release, PERIOD=1000, MIN_PULSE=100, SCALE=2, RESET_POS=128 -> pwm_out high 356 cycles per frame on all channels, frame_start every 1000 cycles, at_target all ones.
- Write ch1=200, STEP=4 -> ch1 width grows 8 cycles per frame (364,372,...). It reaches 500 after 18 boundaries, then at_target[1]=1. Other channels are unchanged.
- Write ch0=0 then ch0=2 while cur=3, STEP=4 -> cur goes to 2, not below; no underflow. Repeat with 255 at top -> no wrap.
- Write coinciding with counter=PERIOD-1 -> that boundary uses the old target; the step toward the new target appears one frame later. Write with wr_ch=NUM_CH -> no register change.
- enable dropped mid-pulse -> pwm_out low next cycle, counter frozen. Re-enable -> frame_start within 1 cycle, full-width pulse.
- SERVO_PWM_FAILSAFE_EN, FAILSAFE_FRAMES=3, ch2 target 250 -> after 3 write-free boundaries failsafe=1 and ch2 ramps back to 128. Next write -> failsafe=0.

Source files
------------

// File: rtl/servo_pwm_pkg.sv
// servo_pwm_pkg: sizing helpers shared by the servo PWM block.
// Optional watchdog in the top is enabled by SERVO_PWM_FAILSAFE_EN.
package servo_pwm_pkg;

  function automatic int clog2(input int v);
    for (int r = 0; r < 32; r++) begin
      if ((longint'(1) << r) >= longint'(v)) return r;
    end
    return 32;
  endfunction

  function automatic int cnt_w(input int period);
    return (clog2(period) < 1) ? 1 : clog2(period);
  endfunction

  function automatic int ch_w(input int num_ch);
    return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
  endfunction

  function automatic bit width_ok(
    input int min_pulse,
    input int scale,
    input int pos_w,
    input int period
  );
    longint top;
    top = longint'(min_pulse)
        + ((longint'(1) << pos_w) - 1)
        * longint'(scale);
    return top < longint'(period);
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// servo_pwm_channel: one servo slot -- target/current position,
// per-frame ramp, pulse width and registered pulse output.
module servo_pwm_channel
  import servo_pwm_pkg::*;
#(
  parameter int POS_W     = 8,
  parameter int CNT_W     = 18,
  parameter int MIN_PULSE = 10000,
  parameter int SCALE     = 39,
  parameter int STEP      = 4,
  parameter int RESET_POS = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             boundary,
  input  logic [CNT_W-1:0] cnt_nxt,
  input  logic             wr_sel,
  input  logic [POS_W-1:0] wr_pos,
  input  logic             force_home,
  output logic             pwm,
  output logic             at_target
);

  localparam int STEP_SAT =
    (STEP >= (1 << POS_W)) ? (1 << POS_W) : STEP;
  localparam logic [POS_W:0] STEP_C =
    (POS_W+1)'(STEP_SAT);
  localparam logic [POS_W-1:0] HOME =
    POS_W'(RESET_POS);
  localparam logic [CNT_W-1:0] MIN_C =
    CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] SCALE_C =
    CNT_W'(SCALE);

  logic [POS_W-1:0] tgt;
  logic [POS_W-1:0] cur;
  logic [POS_W-1:0] cur_nxt;
  logic [POS_W:0]   up;
  logic [POS_W:0]   dn;
  logic [CNT_W-1:0] width_nxt;

  // bounded step toward target, clamped so it never overshoots
  always_comb begin
    up      = {1'b0, tgt} - {1'b0, cur};
    dn      = {1'b0, cur} - {1'b0, tgt};
    cur_nxt = cur;
    if (boundary) begin
      unique case (1'b1)
        (tgt > cur):
          cur_nxt = (up > STEP_C)
                  ? cur + STEP_C[POS_W-1:0]
                  : tgt;
        (tgt < cur):
          cur_nxt = (dn > STEP_C)
                  ? cur - STEP_C[POS_W-1:0]
                  : tgt;
        default:
          cur_nxt = cur;
      endcase
    end
  end

  assign width_nxt = MIN_C
                   + CNT_W'(cur_nxt) * SCALE_C;

  assign at_target = (cur == tgt);

  // target register: host write beats failsafe homing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt <= HOME;
    end else if (wr_sel) begin
      tgt <= wr_pos;
    end else if (force_home) begin
      tgt <= HOME;
    end
  end

  // current position and pulse, both from next-state values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= HOME;
      pwm <= 1'b0;
    end else begin
      cur <= cur_nxt;
      pwm <= run && (cnt_nxt < width_nxt);
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: shared frame counter driving NUM_CH servo channels.
// Define SERVO_PWM_FAILSAFE_EN to add the write-silence watchdog.
module servo_pwm_multi
  import servo_pwm_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int POS_W           = 8,
  parameter int PERIOD          = 200000,
  parameter int MIN_PULSE       = 10000,
  parameter int SCALE           = 39,
  parameter int STEP            = 4,
  parameter int RESET_POS       = 128,
  parameter int FAILSAFE_FRAMES = 50,
  localparam int CNT_W = cnt_w(PERIOD),
  localparam int CH_W  = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [POS_W-1:0]  wr_pos,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start,
  output logic [NUM_CH-1:0] at_target,
  output logic              failsafe
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(PERIOD - 1);
  localparam logic [CH_W:0] NCH =
    (CH_W+1)'(NUM_CH);

  if (!width_ok(MIN_PULSE, SCALE, POS_W, PERIOD)
      || STEP < 1) begin : g_range_bad
    $error("servo_pwm_multi: bad pulse range/step");
  end

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              running;
  logic              boundary;
  logic              wr_valid;
  logic              force_home;
  logic [NUM_CH-1:0] wr_sel;

  // next frame position: fresh frame on (re)enable, wrap at end
  always_comb begin
    cnt_nxt  = cnt;
    boundary = 1'b0;
    if (enable) begin
      if (!running) begin
        cnt_nxt = '0;
      end else if (cnt == LAST) begin
        cnt_nxt  = '0;
        boundary = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  // frame counter, run tracker and registered frame marker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      running     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      running     <= enable;
      frame_start <= enable && (cnt_nxt == '0);
    end
  end

  assign wr_valid = wr_en && ({1'b0, wr_ch} < NCH);

`ifdef SERVO_PWM_FAILSAFE_EN
  localparam int WD_W = cnt_w(FAILSAFE_FRAMES + 1);
  localparam logic [WD_W-1:0] WD_TRIP =
    WD_W'(FAILSAFE_FRAMES - 1);
  localparam logic [WD_W-1:0] WD_MAX =
    WD_W'(FAILSAFE_FRAMES);

  logic [WD_W-1:0] wd;
  logic            fs;

  assign force_home = boundary && !wr_valid
                    && (wd == WD_TRIP);
  assign failsafe   = fs;

  // silence watchdog: writes rearm it, boundaries advance it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd <= '0;
      fs <= 1'b0;
    end else if (wr_valid) begin
      wd <= '0;
      fs <= 1'b0;
    end else if (boundary) begin
      if (wd != WD_MAX) wd <= wd + WD_W'(1);
      if (force_home) fs <= 1'b1;
    end
  end
`else
  localparam int unused_ff = FAILSAFE_FRAMES;

  assign force_home = 1'b0;
  assign failsafe   = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_sel[i] = wr_valid
                     && (wr_ch == CH_W'(i));

    servo_pwm_channel #(
      .POS_W     (POS_W),
      .CNT_W     (CNT_W),
      .MIN_PULSE (MIN_PULSE),
      .SCALE     (SCALE),
      .STEP      (STEP),
      .RESET_POS (RESET_POS)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .run        (enable),
      .boundary   (boundary),
      .cnt_nxt    (cnt_nxt),
      .wr_sel     (wr_sel[i]),
      .wr_pos     (wr_pos),
      .force_home (force_home),
      .pwm        (pwm_out[i]),
      .at_target  (at_target[i])
    );
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: frame scoreboard for servo_pwm_multi.
// Build with SERVO_PWM_FAILSAFE_EN to exercise the watchdog.
`timescale 1ns/1ps
module tb_servo_pwm_multi;

  localparam int NCH    = 3;
  localparam int POS_W  = 8;
  localparam int PERIOD = 1000;
  localparam int MINP   = 100;
  localparam int SCALE  = 2;
  localparam int STEP   = 4;
  localparam int HOME   = 128;
  localparam int FSF    = 3;
`ifdef SERVO_PWM_FAILSAFE_EN
  localparam bit FS_ON = 1'b1;
`else
  localparam bit FS_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             wr_en;
  logic [1:0]       wr_ch;
  logic [POS_W-1:0] wr_pos;
  logic [NCH-1:0]   pwm_out;
  logic             frame_start;
  logic [NCH-1:0]   at_target;
  logic             failsafe;

  int checks = 0;
  int errors = 0;

  servo_pwm_multi #(
    .NUM_CH          (NCH),
    .POS_W           (POS_W),
    .PERIOD          (PERIOD),
    .MIN_PULSE       (MINP),
    .SCALE           (SCALE),
    .STEP            (STEP),
    .RESET_POS       (HOME),
    .FAILSAFE_FRAMES (FSF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_pos      (wr_pos),
    .pwm_out     (pwm_out),
    .frame_start (frame_start),
    .at_target   (at_target),
    .failsafe    (failsafe)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [15:0]            per;
    logic [NCH-1:0][15:0]   w;
    logic [NCH-1:0]         at;
    logic                   fs;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int tgt_m[NCH];
  int cur_m[NCH];
  int wd_m;
  bit fs_m;

  task automatic m_write(input int ch, input int pos);
    if (ch < NCH) begin
      tgt_m[ch] = pos;
      wd_m = 0;
      fs_m = 1'b0;
    end
  endtask

  task automatic m_boundary(input bit wrote);
    for (int i = 0; i < NCH; i++) begin
      if (tgt_m[i] > cur_m[i])
        cur_m[i] = (cur_m[i] + STEP < tgt_m[i])
                 ? cur_m[i] + STEP : tgt_m[i];
      else if (tgt_m[i] < cur_m[i])
        cur_m[i] = (cur_m[i] - STEP > tgt_m[i])
                 ? cur_m[i] - STEP : tgt_m[i];
    end
    if (FS_ON && !wrote) begin
      wd_m++;
      if (wd_m == FSF) begin
        for (int i = 0; i < NCH; i++) tgt_m[i] = HOME;
        fs_m = 1'b1;
      end
    end
  endtask

  function automatic exp_t mk_exp(input int per,
                                  input int trunc);
    exp_t e;
    e.per = 16'(per);
    for (int i = 0; i < NCH; i++) begin
      e.w[i] = (trunc >= 0) ? 16'(trunc)
             : 16'(MINP + cur_m[i] * SCALE);
      e.at[i] = (cur_m[i] == tgt_m[i]);
    end
    e.fs = fs_m;
    return e;
  endfunction

  // ---------------- monitor ----------------
  int             hist_w[64][NCH];
  logic [NCH-1:0] hist_at[64];
  logic           hist_fs[64];
  int             fidx = -1;
  bit             in_fr = 1'b0;
  int             per;
  int             run_c[NCH];
  int             tot_c[NCH];
  bit             opn[NCH];
  logic [NCH-1:0] at_s;
  logic           fs_s;

  task automatic finish_frame();
    exp_t e;
    int   meas;
    if (sb.size() == 0) begin
      chk($sformatf("f%0d_sb_pop", fidx), 0, 1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("f%0d_period", fidx),
          per, int'(e.per));
      for (int i = 0; i < NCH; i++) begin
        meas = (run_c[i] == tot_c[i]) ? run_c[i] : -1;
        if (fidx < 64) hist_w[fidx][i] = meas;
        chk($sformatf("f%0d_width_ch%0d", fidx, i),
            meas, int'(e.w[i]));
      end
      chk($sformatf("f%0d_at_target", fidx),
          int'(at_s), int'(e.at));
      chk($sformatf("f%0d_failsafe", fidx),
          int'(fs_s), int'(e.fs));
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      in_fr = 1'b0;
    end else begin
      if (frame_start) begin
        if (in_fr) finish_frame();
        fidx++;
        in_fr = 1'b1;
        per   = 0;
        at_s  = at_target;
        fs_s  = failsafe;
        if (fidx < 64) begin
          hist_at[fidx] = at_target;
          hist_fs[fidx] = failsafe;
        end
        for (int i = 0; i < NCH; i++) begin
          run_c[i] = 0;
          tot_c[i] = 0;
          opn[i]   = 1'b1;
        end
      end
      if (in_fr) begin
        per++;
        for (int i = 0; i < NCH; i++) begin
          if (pwm_out[i]) begin
            tot_c[i]++;
            if (opn[i]) run_c[i]++;
          end else begin
            opn[i] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input int ch, input int pos);
    wr_en  = 1'b1;
    wr_ch  = 2'(ch);
    wr_pos = 8'(pos);
  endtask

  // one full frame, entered at the negedge of its first cycle
  task automatic frame(input int k1, input int c1,
                       input int p1, input int k2,
                       input int c2, input int p2);
    sb.push_back(mk_exp(PERIOD, -1));
    for (int c = 0; c < PERIOD; c++) begin
      if (c == k1)      put(c1, p1);
      else if (c == k2) put(c2, p2);
      else              wr_en = 1'b0;
      if (c == PERIOD - 1)
        m_boundary(wr_en && (int'(wr_ch) < NCH));
      if (wr_en) m_write(int'(wr_ch), int'(wr_pos));
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  // drop enable 10 cycles into a frame for d cycles
  task automatic gap(input int d);
    sb.push_back(mk_exp(11 + d, 11));
    repeat (10) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("gap_pwm_low", int'(pwm_out), 0);
    chk("gap_fs_low", int'(frame_start), 0);
    put(0, tgt_m[0]);
    m_write(0, tgt_m[0]);
    @(negedge clk);
    wr_en = 1'b0;
    repeat (d - 2) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("reenable_fs", int'(frame_start), 1);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    wr_en  = 1'b0;
    wr_ch  = '0;
    wr_pos = '0;
    for (int i = 0; i < NCH; i++) begin
      tgt_m[i] = HOME;
      cur_m[i] = HOME;
    end
    wd_m = 0;
    fs_m = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_at", int'(at_target), 7);
    chk("rst_failsafe", int'(failsafe), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_pwm", int'(pwm_out), 0);
    chk("idle_fs", int'(frame_start), 0);

    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (frame_start) break;
    end
    chk("first_fs", int'(frame_start), 1);

    frame(100, 1, 200, 200, 0, 3);       // F0
    frame(100, 2, 255, -1, 0, 0);        // F1
    for (int f = 2; f < 32; f++)         // F2..F31
      frame(500, 2, tgt_m[2], -1, 0, 0);
    frame(100, 0, 0, 200, 0, 2);         // F32
    frame(100, 2, 255, -1, 0, 0);        // F33
    frame(100, 3, 0, 200, 1, 200);       // F34
    frame(999, 1, 100, 500, 2, 255);     // F35
    frame(500, 2, 255, -1, 0, 0);        // F36
    frame(500, 2, 255, -1, 0, 0);        // F37
    gap(20);                             // F38
    frame(500, 2, 255, -1, 0, 0);        // F39
    frame(100, 2, 250, -1, 0, 0);        // F40
    for (int f = 41; f < 44; f++)        // F41..F43
      frame(-1, 0, 0, -1, 0, 0);
    frame(100, 1, 100, -1, 0, 0);        // F44
    frame(500, 2, tgt_m[2], -1, 0, 0);   // F45

    repeat (5) @(negedge clk);
    chk("sb_left", sb.size(), 0);

    chk("home_w_ch0", hist_w[0][0], 356);
    chk("home_w_ch2", hist_w[0][2], 356);
    chk("ramp_f1_ch1", hist_w[1][1], 364);
    chk("ramp_f2_ch1", hist_w[2][1], 372);
    chk("ramp_f17_ch1", hist_w[17][1], 492);
    chk("ramp_f18_ch1", hist_w[18][1], 500);
    chk("at_f17_ch1", int'(hist_at[17][1]), 0);
    chk("at_f18_ch1", int'(hist_at[18][1]), 1);
    chk("other_f18_ch2", hist_w[18][2], 100 + 2 * 196);
    chk("low_f32_ch0", hist_w[32][0], 106);
    chk("low_f33_ch0", hist_w[33][0], 104);
    chk("low_f35_ch0", hist_w[35][0], 104);
    chk("top_f32_ch2", hist_w[32][2], 604);
    chk("top_f33_ch2", hist_w[33][2], 610);
    chk("top_f35_ch2", hist_w[35][2], 610);
    chk("bnd_f36_ch1", hist_w[36][1], 500);
    chk("bnd_f37_ch1", hist_w[37][1], 492);
    chk("gap_w_ch1", hist_w[38][1], 11);
    chk("after_gap_ch1", hist_w[39][1], 484);
    chk("fs_f42", int'(hist_fs[42]), 0);
    chk("fs_f43", int'(hist_fs[43]), int'(FS_ON));
    chk("fs_f44", int'(hist_fs[44]), int'(FS_ON));
    chk("fs_f45", int'(hist_fs[45]), 0);
    chk("fs_ramp_ch2", hist_w[44][2],
        FS_ON ? 592 : 600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
